cla_seq_add: RTL and testbench
==============================

# cla_seq_add

Multi-cycle wide adder controller that sequences a single shared `cla_16bit` instance across `NSLICE` 16-bit slices to add two `16*NSLICE`-bit operands. It latches operands through a valid/ready input handshake, walks the slices LSB-first carrying between them in a register, and presents the full sum through a valid/ready output handshake. It sits beside the lab02 CLA datapath as its area-saving sequencer: one 16-bit adder instead of a full-width carry chain.

## Interface
- `NSLICE`, default 4: number of 16-bit slices; operand width W = 16*NSLICE; legal range 2..16.
- `clk`  input  1  rising-edge clock; the only clock.
- `rst`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  operands and `cin` are valid.
- `in_ready`  output  1  block accepts operands; high only in IDLE.
- `a`  input  W  operand A, captured on input handshake.
- `b`  input  W  operand B, captured on input handshake.
- `cin`  input  1  carry into slice 0, captured on input handshake.
- `out_valid`  output  1  `sum`/`cout` are valid; high only in DONE.
- `out_ready`  input  1  consumer accepts result.
- `sum`  output  W  registered result.
- `cout`  output  1  registered carry out of the top slice.
- `ovf`  output  1  signed overflow; present only with `CLA_SEQ_OVF_EN`.

## Operation
- States: IDLE, RUN, DONE. Slice index `idx` is a ceil(log2(NSLICE))-bit counter; carry register `c_q`.
- IDLE: `in_ready`=1. On `in_valid && in_ready`, latch `a`, `b` into operand registers, `c_q`<=`cin`, `idx`<=0, clear `sum`, go RUN. `in_valid` low: stay.
- RUN: the shared `cla_16bit` adds slice `idx` of A and B with `c_q`. Each cycle: `sum[16*idx +: 16]`<=slice sum, `c_q`<=slice carry, `idx`<=`idx`+1. When `idx`==NSLICE-1, also `cout`<=slice carry and go DONE. RUN ignores `in_valid` and `out_ready`.
- DONE: `out_valid`=1; `sum`, `cout` and `ovf` hold stable. On `out_ready`, go IDLE. `out_ready` low: stay indefinitely.
- Arithmetic: unsigned modulo 2^W. `{cout,sum}` = A + B + cin exactly.
- `in_ready` and `out_valid` decode combinationally from state, so neither is high in the same cycle; back-to-back operations need one IDLE cycle.
- Operand registers change only on input handshake. Inputs are don't-care outside handshake.

## Timing
- Reset (async assert, sync release): state IDLE, `idx`=0, `c_q`=0, `sum`=0, `cout`=0, `ovf`=0, `out_valid`=0, `in_ready`=1.
- Reset during RUN or DONE: operation is aborted, no result is produced, and all outputs take their reset values immediately.
- Accept at edge T0. RUN occupies edges T1..T_NSLICE. `out_valid` is high from T_NSLICE onward.
- Latency from accept to `out_valid` is NSLICE cycles (4 at default). Minimum issue interval is NSLICE+2 cycles: RUN, one DONE cycle with `out_ready`=1, one IDLE cycle.
- The carry path per cycle is one 16-bit CLA plus register setup. There is no combinational path from `a`/`b` to any output.

## Configuration
- `CLA_SEQ_OVF_EN` defined: `ovf` port exists. On the final RUN cycle, `ovf`<=(A[W-1]==B[W-1]) && (slice-sum MSB != A[W-1]). It is held through DONE and cleared on the next accept and on reset.
- Undefined: `ovf` port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset/idle: assert `rst` mid-RUN on the 2nd cycle -> `out_valid`=0, `sum`=0, `in_ready`=1 immediately. No result emerges after release.
- Full carry ripple (NSLICE=4): A=0xFFFF_FFFF_FFFF_FFFF, B=0, cin=1 -> exactly 4 cycles after accept, `sum`=0, `cout`=1.
- Plain add: A=0x0001_2345_6789_ABCD, B=0x0000_1111_1111_1111, cin=0 -> `sum`=0x0001_3456_789A_BCDE, `cout`=0.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE -> `out_valid` stays 1, `sum` stable, `in_ready`=0 and a new `in_valid` is ignored. Raise `out_ready` -> IDLE next cycle.
- Back-to-back: stream 3 random ops with `in_valid`=1 and `out_ready`=1 held throughout -> results match the reference model in order, with accepts exactly 6 cycles apart.
- Overflow (`CLA_SEQ_OVF_EN`): A=0x7FFF_FFFF_FFFF_FFFF, B=1, cin=0 -> `sum`=0x8000_0000_0000_0000, `ovf`=1, `cout`=0. A=0x8000_0000_0000_0000, B=0x8000_0000_0000_0000, cin=0 -> `sum`=0, `ovf`=1, `cout`=1.

Source files
------------

// File: rtl/cla_seq_add_if.sv
// cla_seq_add_if: operand/result handshake bundle for the sequential wide adder.
// Latency: none (wires only).
// Backpressure: in_ready/out_valid are driven by the slave and out_ready by the master.
// Ports: in_valid/in_ready/a/b/cin (operand side), out_valid/out_ready/sum/cout (result side),
//        ovf (signed overflow, only with CLA_SEQ_OVF_EN defined).
interface cla_seq_add_if #(
   parameter int NSLICE = 4
);
   localparam int W = 16 * NSLICE;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
`ifdef CLA_SEQ_OVF_EN
   logic         ovf;
`endif

`ifdef CLA_SEQ_OVF_EN
   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );
   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
`else
   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout
   );
   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout
   );
`endif
endinterface

// File: rtl/cla_seq_add.sv
// cla_seq_add: wide adder that walks one shared 16-bit CLA across NSLICE slices, LSB first.
// Latency: NSLICE cycles from input accept to out_valid; issue interval NSLICE+2 cycles.
// Backpressure: in_ready only in IDLE; result holds in DONE until out_ready.
// Ports: clk, rst (async active-high), bus (cla_seq_add_if.slave).
// Optional feature: define CLA_SEQ_OVF_EN to add the registered signed-overflow output bus.ovf.
module cla_seq_add #(
   parameter int NSLICE = 4
) (
   input  logic           clk,
   input  logic           rst,
   cla_seq_add_if.slave   bus
);
   localparam int W     = 16 * NSLICE;
   localparam int IDX_W = $clog2(NSLICE);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q;
   logic             c_q;
   logic [W-1:0]     a_q;
   logic [W-1:0]     b_q;
   logic [W-1:0]     sum_q;
   logic             cout_q;

   logic             in_ready;
   logic             out_valid;
   logic             accept;
   logic             last_slice;
   logic [15:0]      slice_a;
   logic [15:0]      slice_b;
   logic [15:0]      slice_sum;
   logic             slice_cout;

   // Handshake flags decode straight from state so they can never overlap.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) state_d = RUN;
         end
         RUN: begin
            if (idx_q == LAST_IDX) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   assign accept     = bus.in_valid && in_ready;
   assign last_slice = (idx_q == LAST_IDX);
   assign slice_a    = a_q[16*idx_q +: 16];
   assign slice_b    = b_q[16*idx_q +: 16];

   cla_16bit u_cla (
      .a_i (slice_a),
      .b_i (slice_b),
      .c_i (c_q),
      .s_o (slice_sum),
      .c_o (slice_cout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q  <= '0;
         c_q    <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else if (accept) begin
         a_q   <= bus.a;
         b_q   <= bus.b;
         c_q   <= bus.cin;
         idx_q <= '0;
         sum_q <= '0;
      end else if (state_q == RUN) begin
         sum_q[16*idx_q +: 16] <= slice_sum;
         c_q                   <= slice_cout;
         // Wraps to 0 on the last slice when NSLICE is a power of two; idx is
         // reloaded on the next accept anyway.
         idx_q                 <= idx_q + 1'b1;
         if (last_slice) cout_q <= slice_cout;
      end
   end

`ifdef CLA_SEQ_OVF_EN
   logic ovf_q;

   // Signed overflow: operands share a sign but the top slice's sum MSB differs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (accept) begin
         ovf_q <= 1'b0;
      end else if (state_q == RUN && last_slice) begin
         ovf_q <= (a_q[W-1] == b_q[W-1]) && (slice_sum[15] != a_q[W-1]);
      end
   end

   assign bus.ovf = ovf_q;
`endif

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
endmodule

// cla_16bit: 16-bit two-level carry-lookahead adder (four 4-bit groups).
// Latency: combinational.
// Backpressure: none.
// Ports: a_i, b_i (addends), c_i (carry in), s_o (sum), c_o (carry out).
module cla_16bit (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   input  logic        c_i,
   output logic [15:0] s_o,
   output logic        c_o
);
   logic [15:0] g;
   logic [15:0] p;
   logic [15:0] bc;   // carry into each bit
   logic [3:0]  gg;   // group generate
   logic [3:0]  gp;   // group propagate
   logic [3:0]  gc;   // carry into each group

   assign g = a_i & b_i;
   assign p = a_i ^ b_i;

   for (genvar gi = 0; gi < 4; gi++) begin : g_grp
      localparam int B0 = 4 * gi;
      assign gg[gi] = g[B0+3]
                    | (p[B0+3] & g[B0+2])
                    | (p[B0+3] & p[B0+2] & g[B0+1])
                    | (p[B0+3] & p[B0+2] & p[B0+1] & g[B0]);
      assign gp[gi] = &p[B0 +: 4];

      assign bc[B0]   = gc[gi];
      assign bc[B0+1] = g[B0] | (p[B0] & gc[gi]);
      assign bc[B0+2] = g[B0+1] | (p[B0+1] & g[B0]) | (p[B0+1] & p[B0] & gc[gi]);
      assign bc[B0+3] = g[B0+2] | (p[B0+2] & g[B0+1]) | (p[B0+2] & p[B0+1] & g[B0])
                      | (p[B0+2] & p[B0+1] & p[B0] & gc[gi]);
   end

   // Second lookahead level: every group carry is a flat function of c_i.
   assign gc[0] = c_i;
   assign gc[1] = gg[0] | (gp[0] & c_i);
   assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_i);
   assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                | (gp[2] & gp[1] & gp[0] & c_i);
   assign c_o   = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                | (gp[3] & gp[2] & gp[1] & gg[0])
                | (gp[3] & gp[2] & gp[1] & gp[0] & c_i);

   assign s_o = p ^ bc;
endmodule

// File: tb/tb_cla_seq_add.sv
// tb_cla_seq_add: directed-vector bench for the sequential wide adder at NSLICE=4.
// Latency: expects out_valid exactly 4 cycles after accept.
// Backpressure: exercises held out_ready=0 in DONE and streaming with both handshakes high.
module tb_cla_seq_add;
   localparam int NSLICE = 4;
   localparam int W      = 16 * NSLICE;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors    = 0;
   int   miscompares = 0;

   cla_seq_add_if #(.NSLICE(NSLICE)) bus ();

   cla_seq_add #(.NSLICE(NSLICE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present operands for one cycle starting from IDLE; the next edge accepts them.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
      bus.a        = a;
      bus.b        = b;
      bus.cin      = cin;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
   endtask

   // Count cycles after accept until out_valid, bounded at 20.
   task automatic wait_done(output int cycles);
      cycles = 0;
      while (!bus.out_valid && cycles < 20) begin
         step();
         cycles++;
      end
   endtask

   task automatic release_result();
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      int seen;
      // Power-on reset values.
      vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      vectors++; if (bus.sum !== 64'h0) begin miscompares++; $display("FAIL reset_sum: got %h want 0", bus.sum); end
      vectors++; if (bus.cout !== 1'b0) begin miscompares++; $display("FAIL reset_cout: got %b want 0", bus.cout); end
`ifdef CLA_SEQ_OVF_EN
      vectors++; if (bus.ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
`endif
      step();
      rst = 1'b0;
      step();
      // Abort in the 2nd RUN cycle; one slice has already been written into sum.
      issue(64'h1111_2222_3333_4444, 64'h0101_0101_0101_0101, 1'b0);
      step();
      rst = 1'b1;
      #1;
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL midrun_out_valid: got %b want 0", bus.out_valid); end
      vectors++; if (bus.sum !== 64'h0) begin miscompares++; $display("FAIL midrun_sum: got %h want 0", bus.sum); end
      vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL midrun_in_ready: got %b want 1", bus.in_ready); end
      step();
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (bus.out_valid) seen++;
      end
      vectors++; if (seen !== 0) begin miscompares++; $display("FAIL midrun_no_result: got %0d valid cycles want 0", seen); end
   endtask

   task automatic test_ripple();
      int cyc;
      issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
      wait_done(cyc);
      vectors++; if (cyc !== 4) begin miscompares++; $display("FAIL ripple_latency: got %0d want 4", cyc); end
      vectors++; if (bus.sum !== 64'h0) begin miscompares++; $display("FAIL ripple_sum: got %h want 0", bus.sum); end
      vectors++; if (bus.cout !== 1'b1) begin miscompares++; $display("FAIL ripple_cout: got %b want 1", bus.cout); end
      release_result();
      vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL ripple_idle: got %b want 1", bus.in_ready); end
   endtask

   task automatic test_plain();
      int cyc;
      issue(64'h0001_2345_6789_ABCD, 64'h0000_1111_1111_1111, 1'b0);
      wait_done(cyc);
      vectors++; if (cyc !== 4) begin miscompares++; $display("FAIL plain_latency: got %0d want 4", cyc); end
      vectors++; if (bus.sum !== 64'h0001_3456_789A_BCDE) begin miscompares++; $display("FAIL plain_sum: got %h want 0001_3456_789a_bcde", bus.sum); end
      vectors++; if (bus.cout !== 1'b0) begin miscompares++; $display("FAIL plain_cout: got %b want 0", bus.cout); end
      release_result();
   endtask

   task automatic test_backpressure();
      int cyc;
      int bad;
      // 0x00FF + 0x0101 = 0x0200 in every slice, no inter-slice carry.
      issue(64'h00FF_00FF_00FF_00FF, 64'h0101_0101_0101_0101, 1'b0);
      wait_done(cyc);
      vectors++; if (cyc !== 4) begin miscompares++; $display("FAIL bp_latency: got %0d want 4", cyc); end
      // A competing request must be ignored while the result is held.
      bus.a        = 64'hDEAD_BEEF_DEAD_BEEF;
      bus.b        = 64'h1234_5678_9ABC_DEF0;
      bus.cin      = 1'b1;
      bus.in_valid = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (bus.out_valid !== 1'b1 || bus.sum !== 64'h0200_0200_0200_0200 ||
             bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold cycle %0d: out_valid=%b sum=%h in_ready=%b want 1 0200020002000200 0",
                     i, bus.out_valid, bus.sum, bus.in_ready);
         end
         vectors++;
      end
      miscompares += bad;
      bus.in_valid = 1'b0;
      release_result();
      vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_idle: got %b want 1", bus.in_ready); end
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release_valid: got %b want 0", bus.out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] av [3];
      logic [W-1:0] bv [3];
      logic         cv [3];
      logic [W:0]   ev [3];
      int           acc [3];
      int           k_in;
      int           k_out;
      for (int i = 0; i < 3; i++) begin
         av[i] = {$urandom, $urandom};
         bv[i] = {$urandom, $urandom};
         cv[i] = 1'($urandom_range(0, 1));
         ev[i] = {1'b0, av[i]} + {1'b0, bv[i]} + {{W{1'b0}}, cv[i]};
      end
      av[0][W-1] = 1'b1; bv[0][W-1] = 1'b1;   // force at least one carry-out
      ev[0] = {1'b0, av[0]} + {1'b0, bv[0]} + {{W{1'b0}}, cv[0]};
      k_in  = 0;
      k_out = 0;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.a = av[0]; bus.b = bv[0]; bus.cin = cv[0];
      for (int cyc = 0; cyc < 60 && k_out < 3; cyc++) begin
         if (bus.out_valid) begin
            vectors++; if (bus.sum !== ev[k_out][W-1:0]) begin miscompares++; $display("FAIL b2b_sum[%0d]: got %h want %h", k_out, bus.sum, ev[k_out][W-1:0]); end
            vectors++; if (bus.cout !== ev[k_out][W]) begin miscompares++; $display("FAIL b2b_cout[%0d]: got %b want %b", k_out, bus.cout, ev[k_out][W]); end
            k_out++;
         end
         if (bus.in_ready && k_in < 3) begin
            bus.a = av[k_in]; bus.b = bv[k_in]; bus.cin = cv[k_in];
            acc[k_in] = cyc;
            k_in++;
         end else if (bus.in_ready) begin
            bus.in_valid = 1'b0;
         end
         step();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      vectors++; if (k_out !== 3) begin miscompares++; $display("FAIL b2b_count: got %0d results want 3", k_out); end
      if (k_in == 3) begin
         vectors++; if (acc[1] - acc[0] !== 6) begin miscompares++; $display("FAIL b2b_interval01: got %0d want 6", acc[1] - acc[0]); end
         vectors++; if (acc[2] - acc[1] !== 6) begin miscompares++; $display("FAIL b2b_interval12: got %0d want 6", acc[2] - acc[1]); end
      end else begin
         vectors++; miscompares++; $display("FAIL b2b_accepts: got %0d want 3", k_in);
      end
      step();
   endtask

`ifdef CLA_SEQ_OVF_EN
   task automatic test_overflow();
      int cyc;
      issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
      wait_done(cyc);
      vectors++; if (bus.sum !== 64'h8000_0000_0000_0000) begin miscompares++; $display("FAIL ovf1_sum: got %h want 8000000000000000", bus.sum); end
      vectors++; if (bus.ovf !== 1'b1) begin miscompares++; $display("FAIL ovf1_ovf: got %b want 1", bus.ovf); end
      vectors++; if (bus.cout !== 1'b0) begin miscompares++; $display("FAIL ovf1_cout: got %b want 0", bus.cout); end
      release_result();
      issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
      vectors++; if (bus.ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_clear_on_accept: got %b want 0", bus.ovf); end
      wait_done(cyc);
      vectors++; if (bus.sum !== 64'h0) begin miscompares++; $display("FAIL ovf2_sum: got %h want 0", bus.sum); end
      vectors++; if (bus.ovf !== 1'b1) begin miscompares++; $display("FAIL ovf2_ovf: got %b want 1", bus.ovf); end
      vectors++; if (bus.cout !== 1'b1) begin miscompares++; $display("FAIL ovf2_cout: got %b want 1", bus.cout); end
      release_result();
      issue(64'h0001_2345_6789_ABCD, 64'h0000_1111_1111_1111, 1'b0);
      wait_done(cyc);
      vectors++; if (bus.ovf !== 1'b0) begin miscompares++; $display("FAIL ovf3_none: got %b want 0", bus.ovf); end
      release_result();
   endtask
`endif

   initial begin
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.cin       = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      test_reset();
      test_ripple();
      test_plain();
      test_backpressure();
      test_back_to_back();
`ifdef CLA_SEQ_OVF_EN
      test_overflow();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
